// File: rtl/apb4_master_pkg.sv
// Shared types for the APB4 requester bridge: FSM state encoding and APB4 field widths.
package apb4_master_pkg;

  localparam int APB4_PROT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } fsm_t;

endpackage

// File: rtl/apb4_master_bridge.sv
// APB4 requester: converts a valid/ready request stream into APB4 SETUP/ACCESS transfers and
// returns read data, slave error and timeout status on a valid/ready response stream.
module apb4_master_bridge
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ADDR_WIDTH-1:0]      req_addr_i,
  input  logic                       req_write_i,
  input  logic [DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]    req_strb_i,
  input  logic [APB4_PROT_WIDTH-1:0] req_prot_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]      paddr,
  output logic [APB4_PROT_WIDTH-1:0] pprot,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [DATA_WIDTH-1:0]      pwdata,
  output logic [DATA_WIDTH/8-1:0]    pstrb,
  input  logic                       pready,
  input  logic [DATA_WIDTH-1:0]      prdata,
  input  logic                       pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_WIDTH  = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT =
    TIMEOUT_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : {CNT_WIDTH{1'b0}};

  fsm_t                 state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 accept_s;
  logic                 timeout_hit_s;

  // Request acceptance: free in IDLE; in RESP a new request may ride on the response handshake
  always_comb begin
    req_ready_o = 1'b0;
    case (state_r)
      IDLE:    req_ready_o = 1'b1;
      RESP:    req_ready_o = rsp_ready_i;
      default: req_ready_o = 1'b0;
    endcase
  end

  assign accept_s      = req_valid_i & req_ready_o;
  // pready is checked first in ACCESS, so a late ready still beats the abort
  assign timeout_hit_s = TIMEOUT_EN && !pready && (cnt_r == CNT_LIMIT);

  // Request latch: APB address/control/data held from SETUP until the next accepted request
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr  <= {ADDR_WIDTH{1'b0}};
      pwrite <= 1'b0;
      pwdata <= {DATA_WIDTH{1'b0}};
      pstrb  <= {STRB_WIDTH{1'b0}};
      pprot  <= {APB4_PROT_WIDTH{1'b0}};
    end else if (accept_s) begin
      paddr  <= req_addr_i;
      pwrite <= req_write_i;
      pwdata <= req_wdata_i;
      pstrb  <= req_write_i ? req_strb_i : {STRB_WIDTH{1'b0}};
      pprot  <= req_prot_i;
    end
  end

  // Transfer FSM: APB phase strobes, ACCESS wait counter and the registered response
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r       <= IDLE;
      psel          <= 1'b0;
      penable       <= 1'b0;
      cnt_r         <= {CNT_WIDTH{1'b0}};
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= {DATA_WIDTH{1'b0}};
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= SETUP;
            psel    <= 1'b1;
            cnt_r   <= {CNT_WIDTH{1'b0}};
          end
        end
        SETUP: begin
          state_r <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state_r       <= RESP;
            psel          <= 1'b0;
            penable       <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= pwrite ? {DATA_WIDTH{1'b0}} : prdata;
            rsp_err_o     <= pslverr;
            rsp_timeout_o <= 1'b0;
          end else if (timeout_hit_s) begin
            // Abort mid-ACCESS on purpose: a hung slave must not stall the requester forever
            state_r       <= RESP;
            psel          <= 1'b0;
            penable       <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= {DATA_WIDTH{1'b0}};
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_WIDTH'(1'b1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            if (accept_s) begin
              state_r <= SETUP;
              psel    <= 1'b1;
              cnt_r   <= {CNT_WIDTH{1'b0}};
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule
